sap_bus: RTL
============

SAP_BUS -- requirements
Module: sap_bus

Interface
REQ-001 Parameter WIDTH, default 8: bus data width in bits.
REQ-002 Parameter N_SRC, default 5: number of bus sources, range 2..16.
REQ-003 Parameter TRACE_DEPTH, default 8: trace buffer entries, power of two, range 2..64.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 src_en  input  N_SRC  per-source output enable; bit i requests bus drive by source i.
REQ-007 src_data  input  N_SRC*WIDTH  source data, packed; slice i is bits [i*WIDTH +: WIDTH].
REQ-008 bus  output  WIDTH  combinational bus value.
REQ-009 bus_q  output  WIDTH  registered bus value.
REQ-010 contention  output  1  combinational; high when more than one src_en bit is set.
REQ-011 err_sticky  output  1  registered; set by any contention and held until cleared.
REQ-012 err_count  output  8  registered saturating count of contention cycles.
REQ-013 err_clr  input  1  synchronous clear of err_sticky and err_count.
REQ-014 trace_rd  input  1  pop one trace entry.
REQ-015 trace_valid  output  1  trace buffer non-empty.
REQ-016 trace_src  output  $clog2(N_SRC)  source index of the oldest entry.
REQ-017 trace_data  output  WIDTH  data of the oldest entry.
REQ-018 trace_ovf  output  1  sticky flag, set when an entry is overwritten; cleared by err_clr.

Function
REQ-019 Exactly one src_en bit set at index i: bus shall equal slice i of src_data, with no latency.
REQ-020 Zero src_en bits set: bus shall equal bus_q, holding the last driven value.
REQ-021 Two or more src_en bits set: bus shall be all-zero, and contention shall be high in the same cycle.
REQ-022 bus_q shall capture bus on every rising edge, giving 1-cycle latency.
REQ-023 Each contention cycle shall set err_sticky and increment err_count by 1, saturating at 255.
REQ-024 err_clr and contention in the same cycle: clear wins; err_sticky=0 and err_count=0 on the next edge.
REQ-025 A valid transfer is a cycle in which exactly one src_en bit is set; each valid transfer shall push {index, data} into the trace ring.
REQ-026 Trace full plus push: the oldest entry shall be overwritten, the read pointer shall advance, and trace_ovf shall be set.
REQ-027 Simultaneous push and trace_rd when non-empty: both shall occur, and the occupancy shall stay unchanged.
REQ-028 trace_rd while empty shall be ignored, with no pointer movement.
REQ-029 trace_src and trace_data shall be valid only while trace_valid=1; otherwise they shall be 0.
REQ-030 Trace pointers shall wrap modulo TRACE_DEPTH; occupancy shall range 0..TRACE_DEPTH.

Reset
REQ-031 rst low shall asynchronously force bus_q=0, err_sticky=0, err_count=0, trace pointers=0, occupancy=0 and trace_ovf=0.
REQ-032 Reset mid-operation shall discard all trace entries; bus shall then reflect src_en/src_data combinationally, with bus_q=0 as the idle value.
REQ-033 The first rising edge after rst deasserts shall behave as a normal cycle.

Configuration
REQ-034 Macro SAP_BUS_TRACE_EN: when defined, the trace ring per REQ-025..REQ-030 shall be compiled in.
REQ-035 When SAP_BUS_TRACE_EN is undefined, no trace storage shall be built; trace_valid, trace_src, trace_data and trace_ovf shall be tied to 0; trace_rd shall be ignored; ports shall remain present.

Structure
REQ-036 Shared package sap_pkg shall hold the default WIDTH, N_SRC and TRACE_DEPTH constants and the trace entry struct typedef {src, data}.
REQ-037 The trace ring shall be the single sub-module sap_bus_trace (write, read, full/empty, overwrite); the one-hot decode and contention logic shall stay in sap_bus.

Verification
REQ-038 rst low, then src_en=5'b00100 with slice2=8'hA5 -> bus=A5 immediately, bus_q=A5 after 1 edge, contention=0.
REQ-039 src_en=5'b00011 for 3 cycles -> bus=00 and contention=1 in each cycle, err_count=3, err_sticky=1; then err_clr -> both 0.
REQ-040 300 contention cycles -> err_count saturates at 255 (8'hFF).
REQ-041 Trace on, TRACE_DEPTH=8, 10 valid transfers with data 1..10 -> trace_ovf=1; pops return 3..10 in order; trace_valid=0 after the 8th pop.
REQ-042 Trace on, single entry, then push and pop in the same cycle -> occupancy stays 1, and the new entry is presented next.
REQ-043 src_en=0 after driving 8'h3C -> bus and bus_q hold 3C; assert rst mid-run -> bus_q=0 and trace empty, asynchronously.

Source files
------------

// File: rtl/sap_pkg.sv
// Shared constants and the trace entry type for the sap_bus block.
package sap_pkg;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_N_SRC       = 5;
  localparam int DEF_TRACE_DEPTH = 8;
  localparam int DEF_SRC_W       = $clog2(DEF_N_SRC);

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

  typedef struct packed {
    logic [DEF_SRC_W-1:0] src;
    logic [DEF_WIDTH-1:0] data;
  } trace_entry_t;

endpackage

// File: rtl/sap_bus_trace.sv
// Trace ring for sap_bus: records {source, data} of each valid transfer and
// overwrites the oldest entry when full. Instantiated only with SAP_BUS_TRACE_EN.
module sap_bus_trace
  import sap_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SRC_W = DEF_SRC_W,
  parameter int DEPTH = DEF_TRACE_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [SRC_W-1:0] push_src,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             clr,
  output logic             valid,
  output logic [SRC_W-1:0] rd_src,
  output logic [WIDTH-1:0] rd_data,
  output logic             ovf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = DEPTH[PTR_W:0];

  logic [SRC_W-1:0] src_mem  [DEPTH];
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             empty;
  logic             full;
  logic             do_pop;

  assign empty  = (count == '0);
  assign full   = (count == FULL_CNT);
  assign do_pop = pop && !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      src_mem[wr_ptr]  <= push_src;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // A push into a full ring with no pop evicts the oldest entry, so the read
  // pointer advances and occupancy stays at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop || (push && full)) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop && !full) count <= count + 1'b1;
      else if (do_pop && !push) count <= count - 1'b1;
      if (clr) ovf <= 1'b0;
      else if (push && full && !do_pop) ovf <= 1'b1;
    end
  end

  assign valid   = !empty;
  assign rd_src  = empty ? '0 : src_mem[rd_ptr];
  assign rd_data = empty ? '0 : data_mem[rd_ptr];

endmodule

// File: rtl/sap_bus.sv
// Shared-bus arbiter-free mux with contention detection and error counting.
// Optional trace ring is enabled by defining SAP_BUS_TRACE_EN.
module sap_bus
  import sap_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int N_SRC       = DEF_N_SRC,
  parameter int TRACE_DEPTH = DEF_TRACE_DEPTH,
  localparam int SRC_W      = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_SRC-1:0]       src_en,
  input  logic [N_SRC*WIDTH-1:0] src_data,
  output logic [WIDTH-1:0]       bus,
  output logic [WIDTH-1:0]       bus_q,
  output logic                   contention,
  output logic                   err_sticky,
  output logic [7:0]             err_count,
  input  logic                   err_clr,
  input  logic                   trace_rd,
  output logic                   trace_valid,
  output logic [SRC_W-1:0]       trace_src,
  output logic [WIDTH-1:0]       trace_data,
  output logic                   trace_ovf
);

  logic [4:0]       en_cnt;
  logic [SRC_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             one_hot;

  always_comb begin
    en_cnt   = '0;
    sel_idx  = '0;
    sel_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_en[i]) begin
        en_cnt   = en_cnt + 5'd1;
        sel_idx  = SRC_W'(i);
        sel_data = src_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign one_hot    = (en_cnt == 5'd1);
  assign contention = (en_cnt > 5'd1);

  // With no driver the bus keeps its last value, which bus_q already holds.
  always_comb begin
    bus = bus_q;
    if (one_hot) bus = sel_data;
    else if (contention) bus = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_q      <= '0;
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else begin
      bus_q <= bus;
      if (err_clr) begin
        err_sticky <= 1'b0;
        err_count  <= '0;
      end else if (contention) begin
        err_sticky <= 1'b1;
        if (err_count != ERR_COUNT_MAX) err_count <= err_count + 8'd1;
      end
    end
  end

`ifdef SAP_BUS_TRACE_EN
  sap_bus_trace #(
    .WIDTH (WIDTH),
    .SRC_W (SRC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk       (clk),
    .rst       (rst),
    .push      (one_hot),
    .push_src  (sel_idx),
    .push_data (sel_data),
    .pop       (trace_rd),
    .clr       (err_clr),
    .valid     (trace_valid),
    .rd_src    (trace_src),
    .rd_data   (trace_data),
    .ovf       (trace_ovf)
  );
`else
  localparam int unused_depth = TRACE_DEPTH;
  logic unused_trace;

  assign unused_trace = &{1'b0, trace_rd, sel_idx};
  assign trace_valid  = 1'b0;
  assign trace_src    = '0;
  assign trace_data   = '0;
  assign trace_ovf    = 1'b0;
`endif

endmodule
